traffic_source: RTL and testbench

TRAFFIC_SOURCE -- requirements
Module: traffic_source

---
 rtl/traffic_source_if.sv | 25 ++
 rtl/traffic_source.sv | 128 ++++++++++++
 tb/tb_traffic_source.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_source_if.sv
// Flit output channel of the traffic source: valid/ready handshake carrying
// a destination address and a payload word.
interface traffic_source_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_dest;
    logic [DATA_W-1:0] out_data;

    modport master (
        output out_valid,
        output out_dest,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_dest,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/traffic_source.sv
// Random flit injector: an LFSR decides when to fire and picks a destination;
// one flit is held in an output register until the downstream accepts it.
module traffic_source #(
    parameter int          DATA_W = 32,
    parameter int          ADDR_W = 4,
    parameter int          NODES  = 9,
    parameter int          RATE_W = 8,
    parameter int          CNT_W  = 16,
    parameter logic [31:0] SEED   = 32'hACE1_2468
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              send,
    input  logic [RATE_W-1:0] rate,
    input  logic [ADDR_W-1:0] self_id,
    traffic_source_if.master  tx,
    output logic              busy,
    output logic [CNT_W-1:0]  gen_count,
    output logic [CNT_W-1:0]  drop_count
);

    localparam int          SEQ_W     = DATA_W - ADDR_W - 1;
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
    localparam logic [31:0] LFSR_INIT = (SEED == 32'd0) ? 32'd1 : SEED;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       lfsr_q, lfsr_d;
    logic              out_valid_q, out_valid_d;
    logic [ADDR_W-1:0] out_dest_q, out_dest_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic [CNT_W-1:0]  gen_count_q, gen_count_d;
    logic [CNT_W-1:0]  drop_count_q, drop_count_d;

    logic        fire;
    logic        slot_free;
    logic        accept;
    logic [15:0] dest_mod;
    logic [15:0] dest_adj;

    always_comb begin
        lfsr_d       = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);
        fire         = send && (lfsr_q[RATE_W-1:0] < rate);
        slot_free    = !out_valid_q || tx.out_ready;
        accept       = out_valid_q && tx.out_ready;

        // A destination equal to our own address is bumped to the next node.
        dest_mod     = lfsr_q[31:16] % 16'(NODES);
        dest_adj     = dest_mod;
        if (dest_mod == 16'(self_id)) begin
            dest_adj = (dest_mod == 16'(NODES - 1)) ? 16'd0 : dest_mod + 16'd1;
        end

        out_valid_d  = out_valid_q;
        out_dest_d   = out_dest_q;
        out_data_d   = out_data_q;
        seq_d        = seq_q;
        gen_count_d  = gen_count_q;
        drop_count_d = drop_count_q;

        if (fire && slot_free) begin
            out_valid_d = 1'b1;
            out_dest_d  = ADDR_W'(dest_adj);
            out_data_d  = {self_id, 1'b0, seq_q};
            seq_d       = seq_q + 1'b1;
            if (gen_count_q != '1) begin
                gen_count_d = gen_count_q + 1'b1;
            end
        end else if (fire) begin
            if (drop_count_q != '1) begin
                drop_count_d = drop_count_q + 1'b1;
            end
        end else if (accept) begin
            out_valid_d = 1'b0;
        end

        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (send) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (!send) state_d = out_valid_d ? DRAIN : IDLE;
            end
            DRAIN: begin
                if (send)        state_d = ACTIVE;
                else if (accept) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            lfsr_q       <= LFSR_INIT;
            out_valid_q  <= 1'b0;
            out_dest_q   <= '0;
            out_data_q   <= '0;
            seq_q        <= '0;
            gen_count_q  <= '0;
            drop_count_q <= '0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            out_valid_q  <= out_valid_d;
            out_dest_q   <= out_dest_d;
            out_data_q   <= out_data_d;
            seq_q        <= seq_d;
            gen_count_q  <= gen_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign tx.out_valid = out_valid_q;
    assign tx.out_dest  = out_dest_q;
    assign tx.out_data  = out_data_q;
    assign busy         = (state_q != IDLE);
    assign gen_count    = gen_count_q;
    assign drop_count   = drop_count_q;

endmodule

// File: tb/tb_traffic_source.sv
// Self-checking bench for traffic_source: a deterministic vector table from the
// reset seed, hand-written corner sequences and randomized traffic vs a model.
module tb_traffic_source;

    localparam int          DATA_W = 32;
    localparam int          ADDR_W = 4;
    localparam int          NODES  = 9;
    localparam int          RATE_W = 8;
    localparam int          CNT_W  = 16;
    localparam logic [31:0] SEED   = 32'hACE1_2468;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              send = 1'b0;
    logic [RATE_W-1:0] rate = '0;
    logic [ADDR_W-1:0] self_id = 4'd3;
    logic              busy;
    logic [CNT_W-1:0]  gen_count;
    logic [CNT_W-1:0]  drop_count;

    traffic_source_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    traffic_source #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NODES(NODES),
        .RATE_W(RATE_W), .CNT_W(CNT_W), .SEED(SEED)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .send      (send),
        .rate      (rate),
        .self_id   (self_id),
        .tx        (bus),
        .busy      (busy),
        .gen_count (gen_count),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         send;
        logic [7:0] rate;
        bit         ready;
        bit         expValid;
        bit         expBusy;
        int         expGen;
        int         expDrop;
    } vec_t;

    vec_t vecs[8];

    int nChecks = 0;
    int nPass   = 0;

    // Transaction-level reference: one held flit, counters, sequence, and busy
    // meaning "traffic requested or a flit still outstanding".
    logic [31:0] m_lfsr;
    bit          m_valid;
    int          m_dest;
    logic [31:0] m_data;
    logic [26:0] m_seq;
    int          m_gen;
    int          m_drop;
    bit          m_busy;
    int          m_fires;

    function automatic logic [31:0] lfsrNext(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
    endfunction

    task automatic modelReset();
        m_lfsr  = SEED;
        m_valid = 0;
        m_dest  = 0;
        m_data  = 0;
        m_seq   = 0;
        m_gen   = 0;
        m_drop  = 0;
        m_busy  = 0;
        m_fires = 0;
    endtask

    task automatic modelStep(input bit s, input logic [7:0] r, input bit rdy);
        bit fire;
        int d;
        fire = s && (int'(m_lfsr[7:0]) < int'(r));
        if (fire) m_fires++;
        if (fire && (!m_valid || rdy)) begin
            d = int'(m_lfsr[31:16]) % NODES;
            if (d == int'(self_id)) d = (d + 1) % NODES;
            m_valid = 1;
            m_dest  = d;
            m_data  = {self_id, 1'b0, m_seq};
            m_seq   = m_seq + 27'd1;
            if (m_gen < 65535) m_gen++;
        end else if (fire) begin
            if (m_drop < 65535) m_drop++;
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        m_busy = s || m_valid;
        m_lfsr = lfsrNext(m_lfsr);
    endtask

    task automatic checkVal(input string name, input longint actual, input longint expected);
        nChecks++;
        if (actual == expected) nPass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    // Drive one cycle of inputs, advance the model, then sample 1 ns after the edge.
    task automatic applyStimulus(input bit s, input logic [7:0] r, input bit rdy);
        send          = s;
        rate          = r;
        bus.out_ready = rdy;
        modelStep(s, r, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, " valid"}, longint'(bus.out_valid), longint'(m_valid));
        checkVal({tag, " busy"}, longint'(busy), longint'(m_busy));
        checkVal({tag, " gen"}, longint'(gen_count), longint'(m_gen));
        checkVal({tag, " drop"}, longint'(drop_count), longint'(m_drop));
        if (m_valid) begin
            checkVal({tag, " dest"}, longint'(bus.out_dest), longint'(m_dest));
            checkVal({tag, " data"}, longint'(bus.out_data), longint'(m_data));
        end
    endtask

    task automatic resetDut();
        reset         = 1'b1;
        send          = 1'b0;
        rate          = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        modelReset();
    endtask

    task automatic runTable(input string tag);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].send, vecs[i].rate, vecs[i].ready);
            checkVal($sformatf("%s[%0d] valid", tag, i), longint'(bus.out_valid), longint'(vecs[i].expValid));
            checkVal($sformatf("%s[%0d] busy", tag, i), longint'(busy), longint'(vecs[i].expBusy));
            checkVal($sformatf("%s[%0d] gen", tag, i), longint'(gen_count), longint'(vecs[i].expGen));
            checkVal($sformatf("%s[%0d] drop", tag, i), longint'(drop_count), longint'(vecs[i].expDrop));
        end
    endtask

    initial begin
        logic [31:0] heldData;
        logic [26:0] seqExp;
        bit          sawValid;
        bit          held;
        int          flits;
        int          dest0;
        int          dest8;

        // Expected values follow the LFSR stream from SEED: low bytes 68,34,1A,8D,45,...
        vecs[0] = '{0, 8'hFF, 1, 0, 0, 0, 0};
        vecs[1] = '{1, 8'd10, 1, 0, 1, 0, 0};
        vecs[2] = '{1, 8'd30, 1, 1, 1, 1, 0};
        vecs[3] = '{1, 8'hFF, 0, 1, 1, 1, 1};
        vecs[4] = '{1, 8'd0,  0, 1, 1, 1, 1};
        vecs[5] = '{0, 8'hFF, 0, 1, 1, 1, 1};
        vecs[6] = '{0, 8'hFF, 1, 0, 0, 1, 1};
        vecs[7] = '{0, 8'hFF, 1, 0, 0, 1, 1};

        bus.out_ready = 1'b0;
        #12;
        checkVal("reset valid", longint'(bus.out_valid), 0);
        checkVal("reset dest", longint'(bus.out_dest), 0);
        checkVal("reset data", longint'(bus.out_data), 0);
        checkVal("reset busy", longint'(busy), 0);
        checkVal("reset gen", longint'(gen_count), 0);
        checkVal("reset drop", longint'(drop_count), 0);
        resetDut();
        runTable("vec");

        // Back-pressure: one flit held stable while later fires are dropped.
        resetDut();
        heldData = '0;
        held     = 0;
        for (int i = 0; i < 50; i++) begin
            applyStimulus(1, 8'hFF, 0);
            checkOutput("hold");
            if (bus.out_valid && !held) begin
                heldData = bus.out_data;
                held     = 1;
            end
            if (held) checkVal("hold stable", longint'(bus.out_data), longint'(heldData));
        end
        checkVal("hold gen1", longint'(gen_count), 1);
        checkVal("hold drops", longint'(drop_count), longint'(m_fires - 1));
        applyStimulus(0, 8'd0, 1);
        checkOutput("hold release");

        // Drain: send drops while a flit is stuck; no new flits until accepted.
        applyStimulus(1, 8'hFF, 0);
        applyStimulus(1, 8'hFF, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 8'hFF, 0);
            checkOutput("drain");
            checkVal("drain busy", longint'(busy), 1);
        end
        applyStimulus(0, 8'hFF, 1);
        checkOutput("drain done");
        checkVal("drain idle", longint'(busy), 0);

        for (int i = 0; i < 2000; i++) begin
            applyStimulus($urandom_range(0, 9) != 0, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            checkOutput("rand");
            if (bus.out_valid) begin
                checkVal("rand dest range", longint'(bus.out_dest < 4'(NODES)), 1);
                checkVal("rand dest self", longint'(bus.out_dest != self_id), 1);
            end
        end

        // Asynchronous reset while a flit is pending, then the seed stream again.
        applyStimulus(1, 8'hFF, 0);
        applyStimulus(1, 8'hFF, 0);
        checkOutput("pre reset");
        reset = 1'b1;
        #1;
        checkVal("async valid", longint'(bus.out_valid), 0);
        checkVal("async busy", longint'(busy), 0);
        checkVal("async gen", longint'(gen_count), 0);
        checkVal("async drop", longint'(drop_count), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        modelReset();
        runTable("rerun");

        resetDut();
        sawValid = 0;
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(1, 8'd0, 1);
            if (bus.out_valid) sawValid = 1;
        end
        checkVal("rate0 never valid", longint'(sawValid), 0);
        checkVal("rate0 gen", longint'(gen_count), 0);
        checkVal("rate0 drop", longint'(drop_count), 0);

        resetDut();
        seqExp = '0;
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(1, 8'hFF, 1);
            checkOutput("full");
            if (bus.out_valid) begin
                checkVal("full seq", longint'(bus.out_data[26:0]), longint'(seqExp));
                checkVal("full dest range", longint'(bus.out_dest < 4'(NODES)), 1);
                checkVal("full dest self", longint'(bus.out_dest != self_id), 1);
                seqExp = seqExp + 27'd1;
            end
        end

        // Destination distribution with self_id on the last node.
        resetDut();
        self_id = 4'd8;
        flits = 0;
        dest0 = 0;
        dest8 = 0;
        for (int c = 0; c < 20000 && flits < 10000; c++) begin
            applyStimulus(1, 8'hFF, 1);
            if (bus.out_valid) begin
                flits++;
                if (bus.out_dest == 4'd0) dest0++;
                if (bus.out_dest == 4'd8) dest8++;
            end
        end
        checkVal("dist flit budget", longint'(flits >= 10000), 1);
        checkVal("dist no self", longint'(dest8), 0);
        checkVal("dist dest0 share", longint'((dest0 * 100 >= flits * 19) && (dest0 * 100 <= flits * 26)), 1);
        checkVal("dist gen", longint'(gen_count), longint'(m_gen));

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
